bwe_ram_2p: RTL and testbench
=============================

Name: bwe_ram_2p

Overview:
- Parametrised simple-dual-port block RAM for instruction and data memories: port A writes with per-byte enables, port B reads synchronously.
- It extends the fixed 32x16K memory in four ways: configurable width and depth, an optional output pipeline register, same-cycle write-to-read forwarding, and a post-reset clear sequencer that zeroes the array.
- It replaces the instruction and data memories in the CPU top level.

Parameters:
- DWIDTH, 32, data width in bits; must be a multiple of 8.
- AWIDTH, 14, address width.
- DEPTH, 1<<AWIDTH, number of words; must be ≤ 2^AWIDTH.
- OUT_REG, 0, 1 adds one output register stage (read latency 2 instead of 1).
- CLEAR_ON_RST, 1, 1 runs the zero-fill sequencer after every reset; 0 skips it.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- ena  in  1  port A write enable qualifier.
- wea  in  DWIDTH/8  per-byte write enables; bit i covers dina[8i+7:8i].
- addra  in  AWIDTH  write word address.
- dina  in  DWIDTH  write data.
- enb  in  1  read request.
- addrb  in  AWIDTH  read word address.
- doutb  out  DWIDTH  read data.
- doutb_valid  out  1  doutb holds data for a read request.
- init_done  out  1  clear finished; array usable.
- wr_drop  out  1  one-cycle pulse: a write was discarded because the clear was still running.

Behaviour:
- Storage array has no reset; only control and output registers are reset (asynchronously, by rst).
- Reset values:
  - doutb = 0, doutb_valid = 0, wr_drop = 0.
  - init_done = 0 if CLEAR_ON_RST, else 1.
  - Clear counter = 0.
  - State = CLEAR if CLEAR_ON_RST, else IDLE.
- FSM states: CLEAR, IDLE.
- CLEAR state:
  - Each rising edge writes mem[cnt] = 0 and increments cnt.
  - On the edge where cnt == DEPTH-1, the FSM moves to IDLE and init_done is set to 1.
  - init_done therefore rises on the DEPTH-th rising edge after rst deasserts.
  - Port A writes are ignored. If ena && |wea, wr_drop = 1 on the next cycle.
  - Port B reads are ignored: no doutb_valid is produced.
- IDLE state:
  - Each byte i with ena && wea[i] writes mem[addra] byte i from dina. Other bytes are unchanged.
  - Never leaves IDLE except through rst.
- Read, OUT_REG=0:
  - A request (enb=1) at edge N yields doutb and doutb_valid=1 after edge N.
  - doutb_valid is 0 in any cycle following an edge with no request.
  - doutb holds its last value when there is no request.
- Read, OUT_REG=1:
  - One extra register stage; data and valid appear after edge N+1.
  - Back-to-back requests give one result per cycle.
- Forwarding:
  - Applies when a read and a write hit the same address on the same edge (IDLE, enb && ena && addra == addrb).
  - The returned word takes dina for each byte where wea[i]=1, and the old memory contents for the remaining bytes. Result equals the post-write contents.
  - Writes on later edges do not affect a read already issued.
- Out-of-range addresses (≥ DEPTH): writes are ignored; reads return 0 with doutb_valid asserted.
- Reset mid-operation:
  - Pipeline valids are flushed and doutb returns to 0.
  - If CLEAR_ON_RST, the clear restarts at address 0 regardless of progress.
  - Writes in flight on the reset edge are not guaranteed.
- wr_drop is a single-cycle pulse per dropped write and never asserts in IDLE.

Test Plan:
- Clear sequence (DEPTH=16, AWIDTH=4, CLEAR_ON_RST=1): preload junk via the backdoor, pulse rst → init_done rises on the 16th edge after release. Reads of addresses 0..15 then return 0x00000000 with doutb_valid after one cycle.
- Byte-enable write (OUT_REG=0): after clear, write 0xDEADBEEF with wea=4'b1111 to addr 3, then 0x00AA0000 with wea=4'b0100 to addr 3 → read addr 3 returns 0xDEAABEEF one cycle after the request.
- Forwarding: mem[5]=0x11223344; on the same edge write dina=0xAABBCCDD with wea=4'b0011 to addr 5 and read addr 5 → doutb=0x1122CCDD, doutb_valid=1.
- Pipeline (OUT_REG=1): back-to-back reads of addr 0,1,2 holding 0xA,0xB,0xC → doutb_valid high for three consecutive cycles starting two cycles after the first request, with data 0xA,0xB,0xC in order. A gap in requests produces a gap in valid.
- Reset mid-clear: assert rst at clear count 7 → doutb_valid=0, doutb=0, init_done=0. After release, init_done rises 16 edges later (not 9).
- Dropped write: issue ena=1, wea=4'hF, addr 2, data 0x12345678 during CLEAR → wr_drop=1 for exactly one cycle. After init_done, addr 2 reads 0x00000000.

Source files
------------

// File: rtl/bwe_ram_2p.sv
// Simple dual-port RAM: port A byte-masked writes, port B synchronous reads with
// same-edge write forwarding, optional output register and a post-reset zero-fill.
module bwe_ram_2p #(
    parameter int unsigned DWIDTH       = 32,
    parameter int unsigned AWIDTH       = 14,
    parameter int unsigned DEPTH        = 1 << AWIDTH,
    parameter bit          OUT_REG      = 1'b0,
    parameter bit          CLEAR_ON_RST = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic [DWIDTH/8-1:0]   wea,
    input  logic [AWIDTH-1:0]     addra,
    input  logic [DWIDTH-1:0]     dina,
    input  logic                  enb,
    input  logic [AWIDTH-1:0]     addrb,
    output logic [DWIDTH-1:0]     doutb,
    output logic                  doutb_valid,
    output logic                  init_done,
    output logic                  wr_drop
);

    localparam int unsigned       NB        = DWIDTH / 8;
    localparam logic [AWIDTH:0]   DEPTH_W   = (AWIDTH + 1)'(DEPTH);
    localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(DEPTH - 1);

    typedef enum logic [0:0] {StClear, StIdle} state_e;

    logic [DWIDTH-1:0] mem [DEPTH];

    state_e            state_q;
    logic [AWIDTH-1:0] cnt_q;
    logic              a_in_range;
    logic              b_in_range;
    logic              rd_req;
    logic [DWIDTH-1:0] rd_word;
    logic              rd_valid_q;
    logic [DWIDTH-1:0] rd_data_q;

    assign a_in_range = {1'b0, addra} < DEPTH_W;
    assign b_in_range = {1'b0, addrb} < DEPTH_W;
    assign rd_req     = enb && (state_q == StIdle);

    // Control FSM: zero-fill sequencer, then idle forever until the next reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= CLEAR_ON_RST ? StClear : StIdle;
            cnt_q     <= '0;
            init_done <= !CLEAR_ON_RST;
            wr_drop   <= 1'b0;
        end else begin
            wr_drop <= 1'b0;
            unique case (state_q)
                StClear: begin
                    wr_drop <= ena && (|wea);
                    cnt_q   <= cnt_q + AWIDTH'(1);
                    if (cnt_q == LAST_ADDR) begin
                        state_q   <= StIdle;
                        init_done <= 1'b1;
                    end
                end
                StIdle: state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    // Storage carries no reset; the clear sequencer owns it until IDLE.
    always_ff @(posedge clk) begin
        if (state_q == StClear) begin
            if (!rst) mem[cnt_q] <= '0;
        end else if (ena && a_in_range) begin
            for (int i = 0; i < NB; i++) begin
                if (wea[i]) mem[addra][8*i +: 8] <= dina[8*i +: 8];
            end
        end
    end

    // Returned word equals the post-write contents when both ports hit the same address.
    always_comb begin
        rd_word = '0;
        if (b_in_range) begin
            rd_word = mem[addrb];
            if (ena && (addra == addrb)) begin
                for (int i = 0; i < NB; i++) begin
                    if (wea[i]) rd_word[8*i +: 8] = dina[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= rd_req;
            if (rd_req) rd_data_q <= rd_word;
        end
    end

    if (OUT_REG) begin : g_out_reg
        logic              out_valid_q;
        logic [DWIDTH-1:0] out_data_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                out_valid_q <= 1'b0;
                out_data_q  <= '0;
            end else begin
                out_valid_q <= rd_valid_q;
                if (rd_valid_q) out_data_q <= rd_data_q;
            end
        end

        assign doutb       = out_data_q;
        assign doutb_valid = out_valid_q;
    end else begin : g_no_out_reg
        assign doutb       = rd_data_q;
        assign doutb_valid = rd_valid_q;
    end

endmodule

// File: tb/tb_bwe_ram_2p.sv
// Directed bench for bwe_ram_2p: three instances sharing stimulus (latency 1, latency 2,
// and a no-clear instance with DEPTH < 2^AWIDTH for out-of-range accesses).
module tb_bwe_ram_2p;

    logic        clk = 1'b0;
    logic        rst;
    logic        ena;
    logic [3:0]  wea;
    logic [3:0]  addra;
    logic [31:0] dina;
    logic        enb;
    logic [3:0]  addrb;

    logic [31:0] doutb0, doutb1, doutb2;
    logic        v0, v1, v2;
    logic        done0, done1, done2;
    logic        drop0, drop1, drop2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bwe_ram_2p #(.DWIDTH(32), .AWIDTH(4), .DEPTH(16), .OUT_REG(1'b0), .CLEAR_ON_RST(1'b1)) dut0 (
        .clk(clk), .rst(rst), .ena(ena), .wea(wea), .addra(addra), .dina(dina), .enb(enb),
        .addrb(addrb), .doutb(doutb0), .doutb_valid(v0), .init_done(done0), .wr_drop(drop0)
    );

    bwe_ram_2p #(.DWIDTH(32), .AWIDTH(4), .DEPTH(16), .OUT_REG(1'b1), .CLEAR_ON_RST(1'b1)) dut1 (
        .clk(clk), .rst(rst), .ena(ena), .wea(wea), .addra(addra), .dina(dina), .enb(enb),
        .addrb(addrb), .doutb(doutb1), .doutb_valid(v1), .init_done(done1), .wr_drop(drop1)
    );

    bwe_ram_2p #(.DWIDTH(32), .AWIDTH(4), .DEPTH(12), .OUT_REG(1'b0), .CLEAR_ON_RST(1'b0)) dut2 (
        .clk(clk), .rst(rst), .ena(ena), .wea(wea), .addra(addra), .dina(dina), .enb(enb),
        .addrb(addrb), .doutb(doutb2), .doutb_valid(v2), .init_done(done2), .wr_drop(drop2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; ena = 1'b0; wea = 4'h0; addra = '0; dina = '0; enb = 1'b0; addrb = '0;
        step(); step();
        n_checks++; if (doutb0 !== 32'h0) begin n_fail++; $display("FAIL reset_doutb0: got %h want %h", doutb0, 32'h0); end
        n_checks++; if (v0 !== 1'b0) begin n_fail++; $display("FAIL reset_valid0: got %b want 0", v0); end
        n_checks++; if (v1 !== 1'b0) begin n_fail++; $display("FAIL reset_valid1: got %b want 0", v1); end
        n_checks++; if (done0 !== 1'b0) begin n_fail++; $display("FAIL reset_init_done0: got %b want 0", done0); end
        n_checks++; if (done2 !== 1'b1) begin n_fail++; $display("FAIL reset_init_done2: got %b want 1", done2); end
        n_checks++; if (drop0 !== 1'b0) begin n_fail++; $display("FAIL reset_wr_drop0: got %b want 0", drop0); end
    endtask

    task automatic test_dropped_write();
        rst = 1'b0;
        ena = 1'b1; wea = 4'hF; addra = 4'd2; dina = 32'h12345678; enb = 1'b1; addrb = 4'd2;
        step();
        n_checks++; if (drop0 !== 1'b1) begin n_fail++; $display("FAIL drop_pulse: got %b want 1", drop0); end
        n_checks++; if (v0 !== 1'b0) begin n_fail++; $display("FAIL clear_read_ignored: got %b want 0", v0); end
        n_checks++; if (drop2 !== 1'b0) begin n_fail++; $display("FAIL drop_in_idle: got %b want 0", drop2); end
        n_checks++; if (doutb2 !== 32'h12345678) begin n_fail++; $display("FAIL idle_fwd_full: got %h want %h", doutb2, 32'h12345678); end
        ena = 1'b0; enb = 1'b0;
        step();
        n_checks++; if (drop0 !== 1'b0) begin n_fail++; $display("FAIL drop_one_cycle: got %b want 0", drop0); end
        for (int i = 3; i <= 16; i++) begin
            step();
            if (i == 15) begin
                n_checks++; if (done0 !== 1'b0) begin n_fail++; $display("FAIL init_done_early: got %b want 0", done0); end
            end
            if (i == 16) begin
                n_checks++; if (done0 !== 1'b1) begin n_fail++; $display("FAIL init_done_16: got %b want 1", done0); end
            end
        end
        enb = 1'b1; addrb = 4'd2;
        step();
        enb = 1'b0;
        n_checks++; if (doutb0 !== 32'h0 || v0 !== 1'b1) begin n_fail++; $display("FAIL dropped_addr2: got %h/%b want 00000000/1", doutb0, v0); end
        step();
    endtask

    task automatic test_byte_enable();
        ena = 1'b1; wea = 4'hF; addra = 4'd3; dina = 32'hDEADBEEF;
        step();
        wea = 4'b0100; dina = 32'h00AA0000;
        step();
        ena = 1'b0; wea = 4'h0; enb = 1'b1; addrb = 4'd3;
        step();
        n_checks++; if (doutb0 !== 32'hDEAABEEF || v0 !== 1'b1) begin n_fail++; $display("FAIL byte_en_read: got %h/%b want deaabeef/1", doutb0, v0); end
        enb = 1'b0;
        step();
        n_checks++; if (v0 !== 1'b0 || doutb0 !== 32'hDEAABEEF) begin n_fail++; $display("FAIL hold_no_req: got %h/%b want deaabeef/0", doutb0, v0); end
        n_checks++; if (v1 !== 1'b1 || doutb1 !== 32'hDEAABEEF) begin n_fail++; $display("FAIL outreg_latency2: got %h/%b want deaabeef/1", doutb1, v1); end
        step();
    endtask

    task automatic test_forwarding();
        ena = 1'b1; wea = 4'hF; addra = 4'd5; dina = 32'h11223344;
        step();
        wea = 4'b0011; dina = 32'hAABBCCDD; enb = 1'b1; addrb = 4'd5;
        step();
        n_checks++; if (doutb0 !== 32'h1122CCDD || v0 !== 1'b1) begin n_fail++; $display("FAIL fwd_merge: got %h/%b want 1122ccdd/1", doutb0, v0); end
        n_checks++; if (v1 !== 1'b0) begin n_fail++; $display("FAIL fwd_outreg_early: got %b want 0", v1); end
        wea = 4'hF; dina = 32'hFFFFFFFF; enb = 1'b0;
        step();
        n_checks++; if (doutb1 !== 32'h1122CCDD || v1 !== 1'b1) begin n_fail++; $display("FAIL fwd_later_write: got %h/%b want 1122ccdd/1", doutb1, v1); end
        ena = 1'b0; enb = 1'b1;
        step();
        n_checks++; if (doutb0 !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL fwd_post_write: got %h want ffffffff", doutb0); end
        enb = 1'b0;
        step();
    endtask

    task automatic test_pipeline();
        logic [31:0] vals [3];
        vals[0] = 32'hA; vals[1] = 32'hB; vals[2] = 32'hC;
        ena = 1'b1; wea = 4'hF;
        for (int i = 0; i < 3; i++) begin
            addra = 4'(i); dina = vals[i];
            step();
        end
        ena = 1'b0; wea = 4'h0;
        enb = 1'b1; addrb = 4'd0;
        step();
        n_checks++; if (v1 !== 1'b0) begin n_fail++; $display("FAIL pipe_first_early: got %b want 0", v1); end
        n_checks++; if (doutb0 !== 32'hA) begin n_fail++; $display("FAIL pipe_lat1: got %h want a", doutb0); end
        addrb = 4'd1;
        step();
        n_checks++; if (v1 !== 1'b1 || doutb1 !== 32'hA) begin n_fail++; $display("FAIL pipe_a: got %h/%b want a/1", doutb1, v1); end
        addrb = 4'd2;
        step();
        n_checks++; if (v1 !== 1'b1 || doutb1 !== 32'hB) begin n_fail++; $display("FAIL pipe_b: got %h/%b want b/1", doutb1, v1); end
        enb = 1'b0;
        step();
        n_checks++; if (v1 !== 1'b1 || doutb1 !== 32'hC) begin n_fail++; $display("FAIL pipe_c: got %h/%b want c/1", doutb1, v1); end
        step();
        n_checks++; if (v1 !== 1'b0) begin n_fail++; $display("FAIL pipe_drain: got %b want 0", v1); end
        enb = 1'b1; addrb = 4'd0;
        step();
        enb = 1'b0;
        step();
        n_checks++; if (v1 !== 1'b1 || doutb1 !== 32'hA) begin n_fail++; $display("FAIL pipe_after_gap: got %h/%b want a/1", doutb1, v1); end
        step();
        n_checks++; if (v1 !== 1'b0) begin n_fail++; $display("FAIL pipe_gap: got %b want 0", v1); end
    endtask

    task automatic test_reset_mid_clear();
        ena = 1'b1; wea = 4'hF;
        for (int i = 0; i < 16; i++) begin
            addra = 4'(i); dina = 32'hC0DE0000 | 32'(i);
            step();
        end
        ena = 1'b0; wea = 4'h0; enb = 1'b1; addrb = 4'd7;
        step();
        enb = 1'b0;
        n_checks++; if (doutb0 !== 32'hC0DE0007) begin n_fail++; $display("FAIL junk_read: got %h want c0de0007", doutb0); end
        rst = 1'b1;
        #1;
        n_checks++; if (doutb0 !== 32'h0 || v0 !== 1'b0) begin n_fail++; $display("FAIL async_reset_out: got %h/%b want 00000000/0", doutb0, v0); end
        step();
        rst = 1'b0;
        for (int i = 0; i < 7; i++) step();
        rst = 1'b1;
        #1;
        n_checks++; if (done0 !== 1'b0 || v0 !== 1'b0 || doutb0 !== 32'h0) begin n_fail++; $display("FAIL mid_clear_reset: got done=%b v=%b d=%h want 0/0/0", done0, v0, doutb0); end
        step();
        rst = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            step();
            if (i == 9) begin
                n_checks++; if (done0 !== 1'b0) begin n_fail++; $display("FAIL restart_not_9: got %b want 0", done0); end
            end
            if (i == 16) begin
                n_checks++; if (done0 !== 1'b1) begin n_fail++; $display("FAIL restart_16: got %b want 1", done0); end
            end
        end
    endtask

    task automatic test_clear_contents();
        int bad = 0;
        for (int i = 0; i < 16; i++) begin
            enb = 1'b1; addrb = 4'(i);
            step();
            n_checks++;
            if (doutb0 !== 32'h0 || v0 !== 1'b1) begin
                n_fail++; bad++;
                $display("FAIL cleared_word_%0d: got %h/%b want 00000000/1", i, doutb0, v0);
            end
        end
        enb = 1'b0;
        step();
    endtask

    task automatic test_out_of_range();
        ena = 1'b1; wea = 4'hF; addra = 4'd13; dina = 32'h55555555; enb = 1'b1; addrb = 4'd13;
        step();
        n_checks++; if (doutb2 !== 32'h0 || v2 !== 1'b1) begin n_fail++; $display("FAIL oor_read: got %h/%b want 00000000/1", doutb2, v2); end
        ena = 1'b0; wea = 4'h0; addrb = 4'd4;
        step();
        n_checks++; if (doutb2 !== 32'hC0DE0004) begin n_fail++; $display("FAIL no_clear_keeps: got %h want c0de0004", doutb2); end
        n_checks++; if (doutb0 !== 32'h0) begin n_fail++; $display("FAIL cleared_keeps_zero: got %h want 0", doutb0); end
        n_checks++; if (drop2 !== 1'b0 || done2 !== 1'b1) begin n_fail++; $display("FAIL no_clear_ctrl: got drop=%b done=%b want 0/1", drop2, done2); end
        enb = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_dropped_write();
        test_byte_enable();
        test_forwarding();
        test_pipeline();
        test_reset_mid_clear();
        test_clear_contents();
        test_out_of_range();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
